// File: rtl/stump_mem_sequencer.sv
// Memory-access sequencer for the Stump core: stretches single-cycle ren/wen requests into
// wait-stated, ready-handshaked accesses. Define STUMP_MEM_TIMEOUT_EN to add the bus-timeout watchdog.
module stump_mem_sequencer #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int WAIT_STATES    = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] req_rdata,
    output logic              stall,
    output logic              busy,
    output logic              bus_err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_ready
);

    localparam int WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                is_write_reg, is_write_next;
    logic [ADDR_W-1:0]   address_reg, address_next;
    logic [DATA_W-1:0]   data_out_reg, data_out_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                req_any;
    logic                timeout_hit;

    assign req_any = req_ren | req_wen;

`ifdef STUMP_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            bus_err_reg;

    // Ready-wait counter only runs once the mandatory wait states have elapsed.
    always_comb begin
        to_cnt_next = to_cnt_reg;
        timeout_hit = 1'b0;
        if (state_reg != ACCESS) begin
            to_cnt_next = '0;
        end else if (wait_cnt_reg == '0 && !mem_ready) begin
            if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
                to_cnt_next = '0;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_reg  <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            to_cnt_reg  <= to_cnt_next;
            bus_err_reg <= timeout_hit;
        end
    end

    assign bus_err = bus_err_reg;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
    assign bus_err        = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        is_write_next = is_write_reg;
        address_next  = address_reg;
        data_out_next = data_out_reg;
        rdata_next    = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (req_any) begin
                    state_next    = ACCESS;
                    address_next  = req_addr;
                    data_out_next = req_wdata;
                    is_write_next = req_wen;
                    wait_cnt_next = WAIT_W'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (wait_cnt_reg != '0) begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end else if (mem_ready) begin
                    if (!is_write_reg) rdata_next = data_in;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    if (!is_write_reg) rdata_next = '1;
                    state_next = DONE;
                end
            end
            // Core advances at the end of DONE, so a request still visible here is the old one.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            is_write_reg <= 1'b0;
            address_reg  <= '0;
            data_out_reg <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            is_write_reg <= is_write_next;
            address_reg  <= address_next;
            data_out_reg <= data_out_next;
            rdata_reg    <= rdata_next;
        end
    end

    // Gated by rst so a request held during reset cannot raise stall.
    assign stall     = rst & (((state_reg == IDLE) & req_any) | (state_reg == ACCESS));
    assign busy      = (state_reg != IDLE);
    assign mem_ren   = (state_reg == ACCESS) & ~is_write_reg;
    assign mem_wen   = (state_reg == ACCESS) & is_write_reg;
    assign address   = address_reg;
    assign data_out  = data_out_reg;
    assign req_rdata = rdata_reg;

endmodule

// File: tb/tb_stump_mem_sequencer.sv
// Directed bench for stump_mem_sequencer: one instance with no wait states (timeout 4) and one with two.
module tb_stump_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_ren = 1'b0;
    logic        req_wen = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] data_in = '0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    logic [15:0] a_rdata, a_address, a_data_out, b_rdata, b_address, b_data_out;
    logic a_stall, a_busy, a_bus_err, a_mem_ren, a_mem_wen;
    logic b_stall, b_busy, b_bus_err, b_mem_ren, b_mem_wen;

    stump_mem_sequencer #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(0), .TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_ren(req_ren & ~sel), .req_wen(req_wen & ~sel),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(a_rdata),
        .stall(a_stall), .busy(a_busy), .bus_err(a_bus_err),
        .address(a_address), .data_out(a_data_out),
        .mem_ren(a_mem_ren), .mem_wen(a_mem_wen),
        .data_in(data_in), .mem_ready(mem_ready)
    );

    stump_mem_sequencer #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(2), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst),
        .req_ren(req_ren & sel), .req_wen(req_wen & sel),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(b_rdata),
        .stall(b_stall), .busy(b_busy), .bus_err(b_bus_err),
        .address(b_address), .data_out(b_data_out),
        .mem_ren(b_mem_ren), .mem_wen(b_mem_wen),
        .data_in(data_in), .mem_ready(mem_ready)
    );

    logic [15:0] o_rdata, o_address, o_data_out;
    logic o_stall, o_busy, o_bus_err, o_mem_ren, o_mem_wen;
    assign o_rdata    = sel ? b_rdata    : a_rdata;
    assign o_address  = sel ? b_address  : a_address;
    assign o_data_out = sel ? b_data_out : a_data_out;
    assign o_stall    = sel ? b_stall    : a_stall;
    assign o_busy     = sel ? b_busy     : a_busy;
    assign o_bus_err  = sel ? b_bus_err  : a_bus_err;
    assign o_mem_ren  = sel ? b_mem_ren  : a_mem_ren;
    assign o_mem_wen  = sel ? b_mem_wen  : a_mem_wen;

    // Runs one access from posedge+1 to posedge+1; mem_ready stays low for the first ready_low ACCESS cycles.
    task automatic do_access(input logic ren, input logic wen, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] din, input int ready_low,
                             output int stall_n, output int ren_n, output int wen_n, output int berr_n,
                             output int cycles, output int hold_bad, output logic done,
                             output logic first_idle, output logic [15:0] rd);
        int   acc;
        logic in_acc;
        req_ren = ren; req_wen = wen; req_addr = addr; req_wdata = wdata; data_in = din;
        acc = 0; stall_n = 0; ren_n = 0; wen_n = 0; berr_n = 0; cycles = 0; hold_bad = 0;
        done = 1'b0; first_idle = 1'b0; rd = '0;
        mem_ready = (ready_low == 0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            cycles++;
            in_acc = o_busy && o_stall;
            if (c == 0) first_idle = !o_busy && o_stall;
            if (o_stall) stall_n++;
            if (o_mem_ren) ren_n++;
            if (o_mem_wen) wen_n++;
            if (o_bus_err) berr_n++;
            if (in_acc && (o_address !== addr || o_data_out !== wdata)) hold_bad++;
            if (o_busy && !o_stall) begin
                done = 1'b1;
                rd = o_rdata;
            end
            @(posedge clk); #1;
            if (done) break;
            if (in_acc) acc++;
            mem_ready = (acc >= ready_low);
        end
        req_ren = 1'b0; req_wen = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({a_stall, a_busy, a_bus_err, a_mem_ren, a_mem_wen} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {a_stall, a_busy, a_bus_err, a_mem_ren, a_mem_wen}); else passed++;
        checks++; if ({a_address, a_data_out, a_rdata} !== 48'h0) $display("FAIL reset_data: got %h expected 0", {a_address, a_data_out, a_rdata}); else passed++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        sel = 1'b0; req_ren = 1'b1; req_addr = 16'h1111; req_wdata = 16'h2222; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        checks++; if (a_mem_ren !== 1'b1 || a_stall !== 1'b1) $display("FAIL pre_reset_access: got ren=%b stall=%b expected 1 1", a_mem_ren, a_stall); else passed++;
        rst = 1'b0;
        #1;
        checks++; if ({a_mem_ren, a_mem_wen, a_stall, a_busy} !== 4'b0) $display("FAIL async_reset_strobes: got %b expected 0000", {a_mem_ren, a_mem_wen, a_stall, a_busy}); else passed++;
        checks++; if ({a_address, a_data_out, a_rdata} !== 48'h0) $display("FAIL async_reset_data: got %h expected 0", {a_address, a_data_out, a_rdata}); else passed++;
        req_ren = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        int s, r, w, e, cy, hb; logic d, fi; logic [15:0] rd;
        sel = 1'b0;
        do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1234, 0, s, r, w, e, cy, hb, d, fi, rd);
        checks++; if (d !== 1'b1 || cy != 3) $display("FAIL read_len: got done=%b cycles=%0d expected 1 3", d, cy); else passed++;
        checks++; if (s != 2 || r != 1 || w != 0) $display("FAIL read_strobes: got stall=%0d ren=%0d wen=%0d expected 2 1 0", s, r, w); else passed++;
        checks++; if (rd !== 16'h1234 || a_address !== 16'h0040) $display("FAIL read_data: got rdata=%h addr=%h expected 1234 0040", rd, a_address); else passed++;
    endtask

    task automatic test_ready_ignored();
        int s, r, w, e, cy, hb; logic d, fi; logic [15:0] rd;
        sel = 1'b1;
        do_access(1'b1, 1'b0, 16'h0080, 16'h0000, 16'h4321, 0, s, r, w, e, cy, hb, d, fi, rd);
        checks++; if (r != 3 || s != 4 || cy != 5) $display("FAIL wait_ignores_ready: got ren=%0d stall=%0d cycles=%0d expected 3 4 5", r, s, cy); else passed++;
        checks++; if (rd !== 16'h4321) $display("FAIL wait_read_data: got %h expected 4321", rd); else passed++;
    endtask

    task automatic test_write_wait();
        int s, r, w, e, cy, hb; logic d, fi; logic [15:0] rd;
        sel = 1'b1;
        do_access(1'b0, 1'b1, 16'h00FF, 16'hBEEF, 16'h7777, 5, s, r, w, e, cy, hb, d, fi, rd);
        checks++; if (w != 6 || r != 0 || s != 7) $display("FAIL write_strobes: got wen=%0d ren=%0d stall=%0d expected 6 0 7", w, r, s); else passed++;
        checks++; if (hb != 0 || b_address !== 16'h00FF || b_data_out !== 16'hBEEF) $display("FAIL write_hold: got bad=%0d addr=%h dout=%h expected 0 00ff beef", hb, b_address, b_data_out); else passed++;
        checks++; if (rd !== 16'h4321 || cy != 8) $display("FAIL write_rdata_kept: got rdata=%h cycles=%0d expected 4321 8", rd, cy); else passed++;
    endtask

    task automatic test_both();
        int s, r, w, e, cy, hb; logic d, fi; logic [15:0] rd;
        sel = 1'b0;
        do_access(1'b1, 1'b1, 16'h0200, 16'h5A5A, 16'h9999, 0, s, r, w, e, cy, hb, d, fi, rd);
        checks++; if (w != 1 || r != 0) $display("FAIL both_write_wins: got wen=%0d ren=%0d expected 1 0", w, r); else passed++;
        checks++; if (rd !== 16'h1234 || a_data_out !== 16'h5A5A) $display("FAIL both_data: got rdata=%h dout=%h expected 1234 5a5a", rd, a_data_out); else passed++;
    endtask

    task automatic test_back_to_back();
        int s, r, w, e, cy, hb; logic d, fi; logic [15:0] rd;
        sel = 1'b0;
        do_access(1'b1, 1'b0, 16'h0300, 16'h0000, 16'hCAFE, 0, s, r, w, e, cy, hb, d, fi, rd);
        checks++; if (cy != 3 || rd !== 16'hCAFE) $display("FAIL b2b_read: got cycles=%0d rdata=%h expected 3 cafe", cy, rd); else passed++;
        do_access(1'b0, 1'b1, 16'h0304, 16'h0F0F, 16'h0000, 0, s, r, w, e, cy, hb, d, fi, rd);
        checks++; if (fi !== 1'b1 || cy != 3) $display("FAIL b2b_second_start: got idle_first=%b cycles=%0d expected 1 3", fi, cy); else passed++;
        checks++; if (r != 0 || w != 1 || rd !== 16'hCAFE) $display("FAIL b2b_no_reissue: got ren=%0d wen=%0d rdata=%h expected 0 1 cafe", r, w, rd); else passed++;
    endtask

`ifdef STUMP_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int s, r, w, e, cy, hb; logic d, fi; logic [15:0] rd;
        sel = 1'b0;
        do_access(1'b1, 1'b0, 16'h0500, 16'h0000, 16'h1357, 1000, s, r, w, e, cy, hb, d, fi, rd);
        checks++; if (d !== 1'b1 || r != 4 || cy != 6) $display("FAIL timeout_len: got done=%b ren=%0d cycles=%0d expected 1 4 6", d, r, cy); else passed++;
        checks++; if (rd !== 16'hFFFF || e != 1) $display("FAIL timeout_read: got rdata=%h bus_err=%0d expected ffff 1", rd, e); else passed++;
        @(negedge clk);
        checks++; if (a_bus_err !== 1'b0) $display("FAIL timeout_pulse: got %b expected 0", a_bus_err); else passed++;
        @(posedge clk); #1;
        do_access(1'b0, 1'b1, 16'h0502, 16'h2468, 16'h0000, 1000, s, r, w, e, cy, hb, d, fi, rd);
        checks++; if (rd !== 16'hFFFF || e != 1 || w != 4) $display("FAIL timeout_write: got rdata=%h bus_err=%0d wen=%0d expected ffff 1 4", rd, e, w); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_ready_ignored();
        test_write_wait();
        test_both();
        test_back_to_back();
`ifdef STUMP_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stump_mem_sequencer.md
# stump_mem_sequencer

Parametrised memory-access sequencer between the Stump core's memory port and external memory. It turns the core's single-cycle ren/wen requests into a multi-cycle access with programmable wait states and a memory ready handshake. It holds the core with a stall signal until each access completes. The same block serves any datapath and address width, and can add a bus-timeout watchdog.

## Interface
- DATA_W, 16, data bus width
- ADDR_W, 16, address bus width
- WAIT_STATES, 0, mandatory wait cycles before mem_ready is sampled (0..255)
- TIMEOUT_CYCLES, 16, ready-wait limit (used only with STUMP_MEM_TIMEOUT_EN, ≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_ren  in  1  core read request, held while stall=1
- req_wen  in  1  core write request, held while stall=1
- req_addr  in  ADDR_W  core address
- req_wdata  in  DATA_W  core write data
- req_rdata  out  DATA_W  read data, registered, valid in DONE
- stall  out  1  core must hold its request and state
- busy  out  1  state ≠ IDLE
- bus_err  out  1  timeout indication, one-cycle pulse in DONE
- address  out  ADDR_W  memory address, registered
- data_out  out  DATA_W  memory write data, registered
- mem_ren  out  1  memory read strobe
- mem_wen  out  1  memory write strobe
- data_in  in  DATA_W  memory read data
- mem_ready  in  1  memory access complete

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE → ACCESS when req_ren|req_wen:
  - latch req_addr into address and req_wdata into data_out.
  - latch the access type; write wins if both are high.
  - load the wait counter with WAIT_STATES.
- ACCESS, counter ≠ 0: decrement the counter; mem_ready is ignored.
- ACCESS, counter = 0 and mem_ready=1:
  - on a read, capture data_in into req_rdata;
  - → DONE.
- ACCESS, counter = 0 and mem_ready=0: stay in ACCESS.
- DONE → IDLE unconditionally.
  - Requests still asserted in DONE are ignored, because the core advances at the end of DONE.
- mem_ren = ACCESS & read type; mem_wen = ACCESS & write type. Never both.
- stall = (IDLE & (req_ren|req_wen)) | ACCESS. stall is combinational and deasserted in DONE.
- address and data_out hold their last value outside ACCESS.
- req_rdata holds its value until the next completed read; a write leaves it unchanged.
- Counter widths are sized by $clog2 of their maximum value + 1.

## Timing
- Reset (rst=0): immediately, regardless of the clock, force:
  - state IDLE, counters 0;
  - stall, busy, bus_err, mem_ren, mem_wen = 0;
  - address, data_out, req_rdata = 0.
- Reset mid-ACCESS drops the strobes at once, and the access is abandoned.
- Minimum access takes 3 cycles (WAIT_STATES=0, ready=1): IDLE(req) → ACCESS → DONE.
- General access length is 3 + WAIT_STATES + (cycles ready is low after the counter expires).
- The strobes are high for exactly 1 + WAIT_STATES + ready-low cycles.
- A new request is accepted at the earliest in the cycle after DONE, giving back-to-back accesses with no bubble beyond the IDLE cycle.
- mem_ready asserted during wait-state cycles has no effect.

## Configuration
- STUMP_MEM_TIMEOUT_EN defined:
  - a ready-wait counter runs in ACCESS once the wait counter reaches 0.
  - After TIMEOUT_CYCLES consecutive cycles with mem_ready=0, the FSM goes → DONE.
  - On a timed-out read, req_rdata = all ones.
  - On a timed-out write, the write is dropped.
  - bus_err = 1 for that DONE cycle only.
  - The counter clears on entering ACCESS.
- Not defined: ACCESS waits for mem_ready indefinitely, bus_err is tied 0, and no timeout logic is synthesised.

## Test plan
- Reset: assert rst=0 mid-ACCESS → mem_ren/mem_wen/stall fall without a clock edge, and all outputs read 0.
- Read, WAIT_STATES=0, ready=1:
  - stimulus: req_ren, addr 16'h0040, data_in 16'h1234;
  - response: stall high for 2 cycles, mem_ren high 1 cycle, req_rdata=16'h1234 in DONE.
- Write, WAIT_STATES=2, ready held low for 3 extra cycles:
  - stimulus: req_wen, addr 16'h00FF, wdata 16'hBEEF;
  - response: mem_wen high for 6 cycles, address/data_out stable throughout, req_rdata unchanged.
- Both requests high: req_ren=req_wen=1 → write performed, mem_ren never asserted.
- Back-to-back read then write → second access begins the cycle after DONE, and no DONE-cycle request is double-issued.
- With STUMP_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready stuck 0 on a read → DONE after 4 ready-low cycles, req_rdata=16'hFFFF, bus_err pulses for 1 cycle.
